// File: rtl/encoder_responder.sv
// encoder_responder
//   Stands in for an absolute encoder on the half-duplex RS-485 link.
//   Receives a one-byte request (CF) on iRx, validates it, then turns the
//   line around (oDir=1), idles TURN_CLKS cycles and replies on oTx with a
//   position frame built from a snapshot of iAbs/iAbm/iAlarm plus an XOR
//   check byte. UART format: start 0, 8 data LSB first, stop 1.
//
// Ports
//   iClk        system clock (100 MHz)
//   iRst        synchronous active-high reset
//   iRx         request line, asynchronous, idle high
//   iAbs/iAbm   24-bit single-turn position / multi-turn count
//   iAlarm      8-bit alarm flags
//   oTx         response line, idle high
//   oDir        transceiver driver enable (1 = transmit)
//   oBusy       high from request acceptance until oDir falls
//   oFrame_err  one-cycle pulse when a request is rejected
//
// Build option
//   ENCODER_RESPONDER_ID3_EN  defined: data ID 3 answered with the 11-byte
//                             frame; undefined: ID 3 is rejected.
module encoder_responder #(
  parameter int          CLKS_PER_BIT = 40,
  parameter int          TURN_CLKS    = 80,
  parameter logic [7:0]  ENID         = 8'h17
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRx,
  input  logic [23:0] iAbs,
  input  logic [23:0] iAbm,
  input  logic [7:0]  iAlarm,
  output logic        oTx,
  output logic        oDir,
  output logic        oBusy,
  output logic        oFrame_err
);

`ifdef ENCODER_RESPONDER_ID3_EN
  localparam int NBYTES = 11;
`else
  localparam int NBYTES = 6;
`endif
  localparam int CNT_W = $clog2(CLKS_PER_BIT + TURN_CLKS + 1);
  localparam int BI_W  = $clog2(NBYTES);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TURN_END = CNT_W'(TURN_CLKS - 1);

  typedef enum logic [2:0] {IDLE, RX_START, RX_DATA, RX_STOP, CHECK, TURN, TX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;    // rx: data bit 0..7, tx: bit slot 0..9
  logic [BI_W-1:0]  byte_idx, byte_nxt;
  logic [7:0]       sh, sh_nxt;          // received CF byte
  logic             stop_ok, stop_nxt;
  logic             rx_s1, rx_s2, rx_prev;

  logic [7:0]       resp   [NBYTES];
  logic [7:0]       resp_d [NBYTES];
  logic [BI_W-1:0]  last_byte, last_d;   // index of the CRC byte
  logic [7:0]       sf, crc;
  logic [3:0]       id;
  logic             id_ok, req_ok, tx_d;
  logic [2:0]       bsel;

  // 2-flop synchronizer; rx_prev holds the previous synced value for edge detect
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= iRx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign id = sh[6:3];
`ifdef ENCODER_RESPONDER_ID3_EN
  assign id_ok = (id <= 4'd3);
`else
  assign id_ok = (id <= 4'd2);
`endif
  assign req_ok = stop_ok && (sh[2:0] == 3'b010) && (sh[7] == ^sh[6:3]) && id_ok;

  // Response image built from live inputs; captured only on the CHECK cycle.
  // Unused slots stay zero, so XOR over the whole array gives the CRC.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) resp_d[i] = '0;
    sf        = {6'b0, |iAlarm[7:4], |iAlarm[3:0]};
    resp_d[0] = sh;
    resp_d[1] = sf;
    last_d    = BI_W'(5);
    case (id)
      4'd0: {resp_d[4], resp_d[3], resp_d[2]} = iAbs;
      4'd1: {resp_d[4], resp_d[3], resp_d[2]} = iAbm;
      4'd2: begin
        resp_d[2] = ENID;
        last_d    = BI_W'(3);
      end
`ifdef ENCODER_RESPONDER_ID3_EN
      4'd3: begin
        {resp_d[4], resp_d[3], resp_d[2]} = iAbs;
        resp_d[5]                         = ENID;
        {resp_d[8], resp_d[7], resp_d[6]} = iAbm;
        resp_d[9]                         = iAlarm;
        last_d                            = BI_W'(10);
      end
`endif
      default: ;
    endcase
    crc = '0;
    for (int i = 0; i < NBYTES; i++) crc = crc ^ resp_d[i];
    resp_d[last_d] = crc;
  end

  always_ff @(posedge iClk) begin
    if (state == CHECK && req_ok) begin
      resp      <= resp_d;
      last_byte <= last_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      stop_ok  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      sh       <= sh_nxt;
      stop_ok  <= stop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    sh_nxt    = sh;
    stop_nxt  = stop_ok;
    case (state)
      IDLE: if (rx_prev && !rx_s2) begin
        state_nxt = RX_START;
        cnt_nxt   = '0;
      end
      RX_START: if (cnt == HALF_END) begin
        cnt_nxt = '0;
        bit_nxt = '0;
        // a line already back high at mid start bit is a glitch, not an error
        state_nxt = rx_s2 ? IDLE : RX_DATA;
      end else cnt_nxt = cnt + 1'b1;
      RX_DATA: if (cnt == BIT_END) begin
        cnt_nxt = '0;
        sh_nxt  = {rx_s2, sh[7:1]};
        if (bit_idx == 4'd7) state_nxt = RX_STOP;
        else                 bit_nxt   = bit_idx + 1'b1;
      end else cnt_nxt = cnt + 1'b1;
      RX_STOP: if (cnt == BIT_END) begin
        cnt_nxt   = '0;
        stop_nxt  = rx_s2;
        state_nxt = CHECK;
      end else cnt_nxt = cnt + 1'b1;
      CHECK: begin
        cnt_nxt   = '0;
        state_nxt = req_ok ? TURN : IDLE;
      end
      TURN: if (cnt == TURN_END) begin
        cnt_nxt   = '0;
        bit_nxt   = '0;
        byte_nxt  = '0;
        state_nxt = TX;
      end else cnt_nxt = cnt + 1'b1;
      TX: if (cnt == BIT_END) begin
        cnt_nxt = '0;
        if (bit_idx == 4'd9) begin
          bit_nxt = '0;
          if (byte_idx == last_byte) state_nxt = IDLE;
          else                       byte_nxt  = byte_idx + 1'b1;
        end else bit_nxt = bit_idx + 1'b1;
      end else cnt_nxt = cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe and leave the chip glitch-free.
  always_comb begin
    tx_d = 1'b1;
    bsel = '0;
    if (state_nxt == TX) begin
      case (bit_nxt)
        4'd0:    tx_d = 1'b0;
        4'd9:    tx_d = 1'b1;
        default: begin
          bsel = 3'(bit_nxt - 4'd1);
          tx_d = resp[byte_nxt][bsel];
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oTx        <= 1'b1;
      oDir       <= 1'b0;
      oBusy      <= 1'b0;
      oFrame_err <= 1'b0;
    end else begin
      oTx        <= tx_d;
      oDir       <= (state_nxt == TURN) || (state_nxt == TX);
      oBusy      <= (state_nxt == TURN) || (state_nxt == TX);
      oFrame_err <= (state == CHECK) && !req_ok;
    end
  end

endmodule
